// File: rtl/proc_mem_arbiter_pkg.sv
// Shared types for the processor memory arbiter: memory message structs, tag record and port ids.
package proc_mem_arbiter_pkg;

    localparam logic ARB_PORT_IMEM = 1'b0;
    localparam logic ARB_PORT_DMEM = 1'b1;

    typedef struct packed {
        logic       port_id;
        logic [7:0] opaque;
    } arb_tag_t;

    typedef struct packed {
        logic [2:0]  msg_type;
        logic [7:0]  opaque;
        logic [31:0] addr;
        logic [1:0]  len;
        logic [31:0] data;
    } mem_req_4B_t;

    typedef struct packed {
        logic [2:0]  msg_type;
        logic [7:0]  opaque;
        logic [1:0]  test;
        logic [1:0]  len;
        logic [31:0] data;
    } mem_resp_4B_t;

    // The shared port always sees opaque 0; the real value travels in the tag FIFO.
    function automatic mem_req_4B_t clear_req_opaque(input mem_req_4B_t msg);
        mem_req_4B_t m;
        m        = msg;
        m.opaque = 8'h00;
        return m;
    endfunction

endpackage

// File: rtl/proc_mem_arbiter_tag_fifo.sv
// In-order tag FIFO recording the source port and opaque of each outstanding memory request.
module proc_mem_arbiter_tag_fifo
    import proc_mem_arbiter_pkg::*;
#(
    parameter int p_max_out = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  arb_tag_t                     push_tag,
    input  logic                         pop,
    output arb_tag_t                     head,
    output logic [$clog2(p_max_out):0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int PTR_W = $clog2(p_max_out);
    localparam int CNT_W = PTR_W + 1;

    arb_tag_t           mem [p_max_out];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;

    assign head  = mem[rd_ptr];
    assign full  = (count == CNT_W'(p_max_out));
    assign empty = (count == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Tag storage carries data only, so it is left out of reset.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_tag;
    end

endmodule

// File: rtl/proc_mem_arbiter.sv
// Round-robin merge of imem/dmem request ports onto one in-order memory port.
// Optional macro PROC_MEM_ARBITER_STATS_EN adds grant and full-stall counters.
module proc_mem_arbiter
    import proc_mem_arbiter_pkg::*;
#(
    parameter int p_max_out = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  mem_req_4B_t  imem_req_msg,
    input  logic         imem_req_val,
    output logic         imem_req_rdy,
    output mem_resp_4B_t imem_resp_msg,
    output logic         imem_resp_val,
    input  logic         imem_resp_rdy,
    input  mem_req_4B_t  dmem_req_msg,
    input  logic         dmem_req_val,
    output logic         dmem_req_rdy,
    output mem_resp_4B_t dmem_resp_msg,
    output logic         dmem_resp_val,
    input  logic         dmem_resp_rdy,
    output mem_req_4B_t  mem_req_msg,
    output logic         mem_req_val,
    input  logic         mem_req_rdy,
    input  mem_resp_4B_t mem_resp_msg,
    input  logic         mem_resp_val,
    output logic         mem_resp_rdy,
`ifdef PROC_MEM_ARBITER_STATS_EN
    output logic [31:0]  stats_imem_grants,
    output logic [31:0]  stats_dmem_grants,
    output logic [31:0]  stats_full_cycles,
`endif
    output logic         err_orphan
);

    localparam int CNT_W = $clog2(p_max_out) + 1;

    logic                 prio_q;
    logic                 any_val, grant_dmem, has_room, req_fire, resp_fire, resp_to_dmem;
    logic                 tag_full, tag_empty;
    logic [CNT_W-1:0]     tag_count;
    arb_tag_t             push_tag, head_tag;
    mem_req_4B_t          granted_msg;
    mem_resp_4B_t         restored_msg;

    proc_mem_arbiter_tag_fifo #(.p_max_out(p_max_out)) u_tag_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (req_fire),
        .push_tag (push_tag),
        .pop      (resp_fire),
        .head     (head_tag),
        .count    (tag_count),
        .full     (tag_full),
        .empty    (tag_empty)
    );

    // Request side: the full check uses registered count only, so a same-cycle pop never frees a slot.
    always_comb begin
        any_val      = imem_req_val | dmem_req_val;
        grant_dmem   = dmem_req_val & (~imem_req_val | (prio_q == ARB_PORT_DMEM));
        has_room     = (tag_count < CNT_W'(p_max_out));
        granted_msg  = grant_dmem ? dmem_req_msg : imem_req_msg;
        imem_req_rdy = reset & ~grant_dmem & mem_req_rdy & has_room;
        dmem_req_rdy = reset &  grant_dmem & mem_req_rdy & has_room;
        mem_req_val  = reset & any_val & ~tag_full;
        mem_req_msg  = clear_req_opaque(granted_msg);
        req_fire     = mem_req_val & mem_req_rdy;
        push_tag     = '{port_id: grant_dmem, opaque: granted_msg.opaque};
    end

    // Response side: with nothing outstanding the memory port drains and nothing is forwarded.
    always_comb begin
        resp_to_dmem        = (head_tag.port_id == ARB_PORT_DMEM);
        restored_msg        = mem_resp_msg;
        restored_msg.opaque = head_tag.opaque;
        imem_resp_msg       = restored_msg;
        dmem_resp_msg       = restored_msg;
        imem_resp_val       = reset & ~tag_empty & mem_resp_val & ~resp_to_dmem;
        dmem_resp_val       = reset & ~tag_empty & mem_resp_val &  resp_to_dmem;
        mem_resp_rdy        = reset & (tag_empty | (resp_to_dmem ? dmem_resp_rdy : imem_resp_rdy));
        resp_fire           = mem_resp_val & mem_resp_rdy & ~tag_empty;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prio_q     <= ARB_PORT_IMEM;
            err_orphan <= 1'b0;
        end else begin
            if (req_fire) prio_q <= grant_dmem ? ARB_PORT_IMEM : ARB_PORT_DMEM;
            if (mem_resp_val && tag_empty) err_orphan <= 1'b1;
        end
    end

`ifdef PROC_MEM_ARBITER_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stats_imem_grants <= '0;
            stats_dmem_grants <= '0;
            stats_full_cycles <= '0;
        end else begin
            if (req_fire && !grant_dmem) stats_imem_grants <= stats_imem_grants + 32'd1;
            if (req_fire &&  grant_dmem) stats_dmem_grants <= stats_dmem_grants + 32'd1;
            if (any_val && tag_full)     stats_full_cycles <= stats_full_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_proc_mem_arbiter.sv
// Directed bench for proc_mem_arbiter: arbitration order, opaque restore, full/empty limits, reset.
module tb_proc_mem_arbiter;
    import proc_mem_arbiter_pkg::*;

    logic         clk;
    logic         reset;
    mem_req_4B_t  imem_req_msg, dmem_req_msg, mem_req_msg;
    logic         imem_req_val, imem_req_rdy, dmem_req_val, dmem_req_rdy;
    mem_resp_4B_t imem_resp_msg, dmem_resp_msg, mem_resp_msg;
    logic         imem_resp_val, imem_resp_rdy, dmem_resp_val, dmem_resp_rdy;
    logic         mem_req_val, mem_req_rdy, mem_resp_val, mem_resp_rdy;
    logic         err_orphan;

    int errors = 0;
    int checks = 0;

    proc_mem_arbiter #(.p_max_out(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .imem_req_msg  (imem_req_msg),
        .imem_req_val  (imem_req_val),
        .imem_req_rdy  (imem_req_rdy),
        .imem_resp_msg (imem_resp_msg),
        .imem_resp_val (imem_resp_val),
        .imem_resp_rdy (imem_resp_rdy),
        .dmem_req_msg  (dmem_req_msg),
        .dmem_req_val  (dmem_req_val),
        .dmem_req_rdy  (dmem_req_rdy),
        .dmem_resp_msg (dmem_resp_msg),
        .dmem_resp_val (dmem_resp_val),
        .dmem_resp_rdy (dmem_resp_rdy),
        .mem_req_msg   (mem_req_msg),
        .mem_req_val   (mem_req_val),
        .mem_req_rdy   (mem_req_rdy),
        .mem_resp_msg  (mem_resp_msg),
        .mem_resp_val  (mem_resp_val),
        .mem_resp_rdy  (mem_resp_rdy),
        .err_orphan    (err_orphan)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic mem_req_4B_t mk_req(input logic [7:0] opq, input logic [31:0] addr);
        mem_req_4B_t m;
        m = '{msg_type: 3'd0, opaque: opq, addr: addr, len: 2'd0, data: 32'h0};
        return m;
    endfunction

    function automatic mem_resp_4B_t mk_resp(input logic [31:0] data);
        mem_resp_4B_t m;
        m = '{msg_type: 3'd0, opaque: 8'h00, test: 2'd0, len: 2'd0, data: data};
        return m;
    endfunction

    initial begin
        reset         = 1'b0;
        imem_req_msg  = mk_req(8'h00, 32'h0);
        dmem_req_msg  = mk_req(8'h00, 32'h0);
        imem_req_val  = 1'b0;
        dmem_req_val  = 1'b0;
        imem_resp_rdy = 1'b1;
        dmem_resp_rdy = 1'b1;
        mem_req_rdy   = 1'b0;
        mem_resp_msg  = mk_resp(32'h0);
        mem_resp_val  = 1'b0;
        step();
        step();
        chk("rst_mem_req_val", mem_req_val, 0);
        chk("rst_imem_req_rdy", imem_req_rdy, 0);
        chk("rst_mem_resp_rdy", mem_resp_rdy, 0);
        chk("rst_imem_resp_val", imem_resp_val, 0);
        chk("rst_err_orphan", err_orphan, 0);
        reset = 1'b1;

        // Both ports valid: grants alternate starting with imem
        mem_req_rdy  = 1'b1;
        imem_req_val = 1'b1;
        dmem_req_val = 1'b1;
        imem_req_msg = mk_req(8'h11, 32'h10);
        dmem_req_msg = mk_req(8'h22, 32'h20);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("rr_addr", mem_req_msg.addr, (i % 2 == 0) ? 32'h10 : 32'h20);
            chk("rr_imem_rdy", imem_req_rdy, (i % 2 == 0) ? 1 : 0);
            chk("rr_dmem_rdy", dmem_req_rdy, (i % 2 == 0) ? 0 : 1);
            chk("rr_opaque_zero", mem_req_msg.opaque, 8'h00);
            step();
        end
        imem_req_val = 1'b0;
        dmem_req_val = 1'b0;
        step();
        step();
        mem_resp_val = 1'b1;
        for (int i = 0; i < 4; i++) begin
            mem_resp_msg = mk_resp(32'hA0 + i);
            #1;
            chk("rr_resp_imem_val", imem_resp_val, (i % 2 == 0) ? 1 : 0);
            chk("rr_resp_dmem_val", dmem_resp_val, (i % 2 == 0) ? 0 : 1);
            chk("rr_resp_opaque", (i % 2 == 0) ? imem_resp_msg.opaque : dmem_resp_msg.opaque,
                (i % 2 == 0) ? 8'h11 : 8'h22);
            step();
        end
        mem_resp_val = 1'b0;

        // Opaque stripped on the way out and restored on the way back
        imem_req_val = 1'b1;
        imem_req_msg = mk_req(8'h5A, 32'h100);
        #1;
        chk("opq_req_val", mem_req_val, 1);
        chk("opq_req_addr", mem_req_msg.addr, 32'h100);
        chk("opq_req_opaque", mem_req_msg.opaque, 8'h00);
        step();
        imem_req_val = 1'b0;
        step();
        mem_resp_val = 1'b1;
        mem_resp_msg = mk_resp(32'hDEAD);
        #1;
        chk("opq_resp_val", imem_resp_val, 1);
        chk("opq_resp_opaque", imem_resp_msg.opaque, 8'h5A);
        chk("opq_resp_data", imem_resp_msg.data, 32'hDEAD);
        chk("opq_dmem_val", dmem_resp_val, 0);
        step();
        mem_resp_val = 1'b0;

        // Fill to p_max_out; fifth dmem request stalls until a slot frees
        dmem_req_val = 1'b1;
        for (int i = 0; i < 4; i++) begin
            dmem_req_msg = mk_req(8'h30 + 8'(i), 32'h300);
            #1;
            chk("full_fill_rdy", dmem_req_rdy, 1);
            step();
        end
        dmem_req_msg = mk_req(8'h34, 32'h300);
        #1;
        chk("full_stall_rdy", dmem_req_rdy, 0);
        chk("full_stall_val", mem_req_val, 0);
        step();
        mem_resp_val = 1'b1;
        mem_resp_msg = mk_resp(32'h0);
        #1;
        chk("full_same_cycle_rdy", dmem_req_rdy, 0);
        chk("full_resp_val", dmem_resp_val, 1);
        chk("full_resp_opaque", dmem_resp_msg.opaque, 8'h30);
        step();
        mem_resp_val = 1'b0;
        #1;
        chk("full_next_cycle_rdy", dmem_req_rdy, 1);
        step();
        dmem_req_val = 1'b0;
        mem_resp_val = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("full_drain_val", dmem_resp_val, 1);
            chk("full_drain_opaque", dmem_resp_msg.opaque, 8'h31 + 8'(i));
            step();
        end
        mem_resp_val = 1'b0;

        // Response back-pressure from dmem
        dmem_req_val = 1'b1;
        dmem_req_msg = mk_req(8'h77, 32'h400);
        step();
        dmem_req_val  = 1'b0;
        dmem_resp_rdy = 1'b0;
        mem_resp_val  = 1'b1;
        mem_resp_msg  = mk_resp(32'hBEEF);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_mem_resp_rdy", mem_resp_rdy, 0);
            chk("bp_resp_val", dmem_resp_val, 1);
            chk("bp_resp_opaque", dmem_resp_msg.opaque, 8'h77);
            step();
        end
        dmem_resp_rdy = 1'b1;
        #1;
        chk("bp_release_rdy", mem_resp_rdy, 1);
        chk("bp_release_data", dmem_resp_msg.data, 32'hBEEF);
        step();
        mem_resp_val = 1'b0;
        #1;
        chk("bp_empty_val", dmem_resp_val, 0);
        chk("bp_no_orphan", err_orphan, 0);

        // Orphan response sets the sticky flag; reset clears it
        mem_resp_val = 1'b1;
        #1;
        chk("orph_drain_rdy", mem_resp_rdy, 1);
        chk("orph_imem_val", imem_resp_val, 0);
        chk("orph_dmem_val", dmem_resp_val, 0);
        step();
        mem_resp_val = 1'b0;
        chk("orph_set", err_orphan, 1);
        step();
        step();
        chk("orph_sticky", err_orphan, 1);
        reset = 1'b0;
        #1;
        chk("orph_reset_clear", err_orphan, 0);
        step();
        reset = 1'b1;

        // Asynchronous reset with two requests outstanding
        imem_req_val = 1'b1;
        imem_req_msg = mk_req(8'h41, 32'h200);
        step();
        imem_req_msg = mk_req(8'h42, 32'h200);
        step();
        dmem_req_val = 1'b1;
        mem_resp_val = 1'b1;
        mem_resp_msg = mk_resp(32'h0);
        #1;
        chk("ar_pre_resp_val", imem_resp_val, 1);
        chk("ar_pre_resp_opaque", imem_resp_msg.opaque, 8'h41);
        chk("ar_pre_req_val", mem_req_val, 1);
        reset = 1'b0;
        #1;
        chk("ar_mem_req_val", mem_req_val, 0);
        chk("ar_imem_resp_val", imem_resp_val, 0);
        chk("ar_dmem_resp_val", dmem_resp_val, 0);
        chk("ar_imem_req_rdy", imem_req_rdy, 0);
        chk("ar_dmem_req_rdy", dmem_req_rdy, 0);
        chk("ar_mem_resp_rdy", mem_resp_rdy, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("ar_prio_imem_rdy", imem_req_rdy, 1);
        chk("ar_prio_dmem_rdy", dmem_req_rdy, 0);
        chk("ar_prio_addr", mem_req_msg.addr, 32'h200);
        chk("ar_count_empty_val", imem_resp_val, 0);
        chk("ar_count_empty_rdy", mem_resp_rdy, 1);
        chk("ar_err_orphan", err_orphan, 0);
        imem_req_val = 1'b0;
        dmem_req_val = 1'b0;
        mem_resp_val = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/proc_mem_arbiter.md
Name: proc_mem_arbiter

Overview:
- Sits directly downstream of the processor's imem and dmem request/response ports; merges both onto one shared memory port.
- Requests arbitrate round-robin; the memory returns responses in order.
- An internal tag FIFO records the source port and original opaque of each outstanding request; each response is routed back to its requester with the opaque restored.

Parameters:
- p_max_out, 4, maximum outstanding requests (tag FIFO depth); power of 2, >= 2.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (asserted at 0); release is synchronised externally.
- imem_req_msg  in  mem_req_4B_t  port-0 request.
- imem_req_val / imem_req_rdy  in/out  1  port-0 request handshake.
- imem_resp_msg  out  mem_resp_4B_t  port-0 response.
- imem_resp_val / imem_resp_rdy  out/in  1  port-0 response handshake.
- dmem_req_msg, dmem_req_val, dmem_req_rdy, dmem_resp_msg, dmem_resp_val, dmem_resp_rdy: same as the imem signals, for port 1.
- mem_req_msg  out  mem_req_4B_t  merged request.
- mem_req_val / mem_req_rdy  out/in  1  merged request handshake.
- mem_resp_msg  in  mem_resp_4B_t  merged response.
- mem_resp_val / mem_resp_rdy  in/out  1  merged response handshake.
- err_orphan  out  1  sticky: a response arrived with no outstanding request.

Behaviour:
- Reset (reset==0, asynchronous):
  - Tag FIFO empty; pointers and count = 0.
  - Priority pointer selects port 0 (imem); err_orphan = 0.
  - All val/rdy outputs 0.
- Request path is combinational, zero cycles of latency, with no request buffering.
  - grant_ok = mem_req_rdy && (count < p_max_out).
  - If both ports are valid, grant the port indicated by the priority pointer; otherwise grant the single valid port.
  - The granted port's req_rdy equals grant_ok; the other port's req_rdy = 0.
  - mem_req_val = (either port valid) && count < p_max_out.
  - mem_req_msg is the granted message with opaque replaced by 8'h00.
- On a fire (mem_req_val && mem_req_rdy):
  - Push {port_id, original opaque} into the tag FIFO.
  - Priority pointer moves to the port that was not granted. The pointer is unchanged when there is no fire.
- Full boundary: at count == p_max_out, no grant occurs, even if a response dequeues in the same cycle. This is deliberate: it breaks the req/resp combinational loop.
- Response path:
  - When count > 0, the FIFO head selects the destination port.
  - dest_resp_val = mem_resp_val; dest_resp_msg = mem_resp_msg with opaque restored from the FIFO.
  - Non-destination resp_val = 0.
  - mem_resp_rdy = destination port's resp_rdy.
  - A fire pops the FIFO head.
- Empty boundary:
  - mem_resp_rdy = 1 (drain) and both resp_val = 0.
  - mem_resp_val at count == 0 sets err_orphan, which holds until reset.
- Simultaneous push and pop: count is unchanged; both pointers advance.
- Pointer arithmetic:
  - Pointers are log2(p_max_out) bits and wrap naturally.
  - count is log2(p_max_out)+1 bits.
- Reset mid-operation: all outstanding tags are discarded; responses that arrive afterwards are orphans.
- Only the req/resp messages are X-tolerant; no val output may go X after reset.

Optional Feature:
- Macro: PROC_MEM_ARBITER_STATS_EN.
- When defined, adds outputs:
  - stats_imem_grants (32 bits) and stats_dmem_grants (32 bits): count fires per port, wrapping at 2^32.
  - stats_full_cycles (32 bits): counts cycles with a valid request blocked by count == p_max_out.
  - All counters are reset to 0.
- When undefined, these ports and counters are absent and the block's behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - typedef arb_tag_t {logic port_id; logic [7:0] opaque;}.
  - Constants ARB_PORT_IMEM=0 and ARB_PORT_DMEM=1.
  - mem_req_4B_t and mem_resp_4B_t, reused from the existing mem-msgs definitions.
- One sub-module: proc_mem_arbiter_tag_fifo (depth p_max_out, holds arb_tag_t, exposes push/pop/count/full/empty). The arbiter and routing logic live in the top module.

Test Plan:
- Both ports hold val for 4 cycles, mem_req_rdy=1, memory returns responses after 2 cycles → grants alternate imem, dmem, imem, dmem; responses are routed to imem, dmem, imem, dmem.
- imem sends opaque 8'h5A to addr 0x100 → mem sees opaque 8'h00; the imem response carries opaque 8'h5A; dmem_resp_val stays 0.
- Memory response withheld while 5 dmem requests are issued with p_max_out=4 → 4 fire, the 5th stalls (dmem_req_rdy=0); the first response frees a slot and the 5th fires the following cycle, not the same cycle.
- dmem_resp_rdy=0 for 3 cycles while its response is pending → mem_resp_rdy=0 for 3 cycles; message held; delivered on the 4th cycle.
- mem_resp_val pulsed with count=0 → err_orphan=1 and stays 1; reset low → err_orphan=0 and count=0.
- Reset asserted asynchronously with 2 requests outstanding → all val outputs drop to 0 immediately; after release, the priority pointer selects imem and count=0.
